divider: RTL
============

# divider

Sequential 32-bit unsigned divider for the MIPS datapath; the divide counterpart of the multiplier. Triggered by the ALU control code on `Signal`, it runs a restoring shift-subtract loop for 32 cycles. It returns `{remainder, quotient}` on a 64-bit bus that feeds the HI/LO registers.

## Interface
- `WIDTH`, default 32: operand width; result is 2*WIDTH.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `dataA`  in  32  dividend.
- `dataB`  in  32  divisor.
- `Signal`  in  6  ALU function code; DIVU = 6'b011011 starts an operation.
- `dataOut`  out  64  {remainder[63:32], quotient[31:0]} (HI = remainder, LO = quotient).
- `busy`  out  1  high while iterating.
- `done`  out  1  one-cycle pulse when `dataOut` is updated.
- `divzero`  out  1  registered with `done`; set when the latched divisor was 0.

## Operation
- States:
  - IDLE: waits for a start.
  - RUN: iterates; 6-bit `count` runs 0..31.
  - DONE: lasts one cycle.
- IDLE → RUN: taken when `Signal == DIVU` at a posedge.
  - Latch `dataA` into the quotient/dividend shift register and `dataB` into the divisor register.
  - Clear the 33-bit partial remainder and set `count = 0`.
- Each RUN cycle performs one restoring step:
  - `{rem, q} <<= 1`.
  - `diff = rem - divisor` (33-bit).
  - If `diff` is non-negative: `rem = diff` and `q[0] = 1`; else keep `rem` and set `q[0] = 0`.
  - Increment `count`.
- RUN → DONE: taken after the step with `count == 31`.
  - `dataOut <= {rem[31:0], q}`.
  - `divzero <= (divisor == 0)`.
- DONE → IDLE: unconditional.
- `Signal` and operand changes during RUN or DONE are ignored. Operands are used only as latched.
- Any non-DIVU code in IDLE is ignored.
- Divide by zero needs no special path. The algorithm naturally yields quotient 0xFFFFFFFF and remainder = dividend, and `divzero` is set.
- `dataOut` holds the last result until the next completion; it is not cleared at start.

## Timing
- Reset (asynchronous, any state, including mid-RUN):
  - State goes to IDLE; `dataOut`, `busy`, `done`, `divzero` and all internal registers go to 0.
  - The partial operation is discarded.
- Start sampled at posedge N. `busy` is high from after posedge N until posedge N+32.
- Iterations occur at posedges N+1 through N+32.
- `dataOut`, `done` and `divzero` update at posedge N+32. `done` is high for exactly the cycle N+32..N+33.
- Latency: result visible 32 cycles after the start edge.
- Minimum start-to-start spacing: 34 cycles, since a start is accepted only in IDLE.
- `busy` and `done` are never high in the same cycle.

## Configuration
- `DIV_SIGNED_EN` defined:
  - DIV = 6'b011010 is additionally accepted in IDLE.
  - At load, the divider records the signs of `dataA` and `dataB` and stores their magnitudes.
  - At the RUN → DONE write, the quotient is negated if the signs differ. The remainder takes the sign of the dividend.
  - Divide by zero bypasses the correction and writes `{dataA, 32'hFFFFFFFF}`.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
  - Latency is identical to DIVU.
- `DIV_SIGNED_EN` undefined: DIV is an unrecognized code and is ignored. No sign registers or negation logic are present.

## Structure
- Package `div_pkg` holds:
  - Constants `DIVU`, `DIV` and `MULTU`.
  - `WIDTH`.
  - State enum `div_state_t` {IDLE, RUN, DONE}.
- The package is shared with the multiplier and ALU control.
- One combinational sub-module, `div_step`:
  - Inputs: 33-bit rem, 32-bit q, divisor.
  - Outputs: next rem, next q (one restoring step).
- The top level holds the FSM, counter, sign handling and output registers.

## Test plan
- Reset then DIVU with A=100, B=7:
  - `busy` is high for 32 cycles.
  - `done` pulses at start+32.
  - `dataOut` = {32'd2, 32'd14}; `divzero` = 0.
- DIVU with A=0xFFFFFFFF, B=1 → `dataOut` = {0, 0xFFFFFFFF}. Then A=5, B=9 → {5, 0}.
- DIVU with A=0x12345678, B=0 → `dataOut` = {0x12345678, 0xFFFFFFFF}, `divzero` = 1.
- Start A=50, B=5:
  - Toggle `dataA`/`dataB` and reassert DIVU during RUN → result stays {0, 10}, no second `done`.
  - Assert `reset` at cycle 10 of a new run → all outputs 0, no `done`.
- With `DIV_SIGNED_EN`:
  - DIV -7/2 → {0xFFFFFFFF, 0xFFFFFFFD}.
  - DIV 7/-2 → {1, 0xFFFFFFFD}.
  - DIV 0x80000000 / -1 → {0, 0x80000000}.
- Without `DIV_SIGNED_EN`: DIV code in IDLE → `busy` stays 0 and `dataOut` is unchanged.

Source files
------------

// File: rtl/div_pkg.sv
// Shared opcode constants and state type for the divider, multiplier and ALU
// control.
package div_pkg;

   localparam int WIDTH = 32;

   // ALU function codes
   localparam logic [5:0] MULTU = 6'b011001;
   localparam logic [5:0] DIV   = 6'b011010;
   localparam logic [5:0] DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shifts {rem, q} left by one, then
// subtracts the divisor from the partial remainder when it fits and records
// the outcome in the new quotient LSB.
module div_step
   import div_pkg::*;
#(
   parameter int W = WIDTH
) (
   input  logic [W:0]   rem_i,
   input  logic [W-1:0] q_i,
   input  logic [W-1:0] divisor_i,
   output logic [W:0]   rem_o,
   output logic [W-1:0] q_o
);

   logic [W:0] rem_sh;
   logic       take;

   // Shift, compare and conditionally subtract.
   always_comb begin
      // The true shifted remainder is {rem_i, q_i[W-1]}; if its top bit
      // rem_i[W] is set, it is certainly >= divisor, and the W+1-bit
      // difference is still exact because the result is below the divisor.
      rem_sh = {rem_i[W-1:0], q_i[W-1]};
      take   = rem_i[W] | (rem_sh >= {1'b0, divisor_i});
      rem_o  = rem_sh;
      q_o    = {q_i[W-2:0], 1'b0};
      if (take) begin
         rem_o   = rem_sh - {1'b0, divisor_i};
         q_o[0]  = 1'b1;
      end
   end

endmodule

// File: rtl/divider.sv
// Sequential restoring divider for the MIPS HI/LO path. DIVU starts a
// 32-iteration shift-subtract loop; dataOut = {remainder, quotient}.
// Optional feature macro: DIV_SIGNED_EN adds signed DIV with sign correction.
module divider
   import div_pkg::*;
#(
   parameter int WIDTH = div_pkg::WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   dataA,
   input  logic [WIDTH-1:0]   dataB,
   input  logic [5:0]         Signal,
   output logic [2*WIDTH-1:0] dataOut,
   output logic               busy,
   output logic               done,
   output logic               divzero
);

   localparam logic [5:0] LAST = 6'(WIDTH - 1);

   div_state_t         state_q, state_d;
   logic [5:0]         count_q, count_d;
   logic [WIDTH:0]     rem_q, rem_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [WIDTH-1:0]   divisor_q, divisor_d;
   logic [2*WIDTH-1:0] dout_q, dout_d;
   logic               done_q, done_d;
   logic               divzero_q, divzero_d;

   logic [WIDTH:0]     step_rem;
   logic [WIDTH-1:0]   step_q;
   logic [WIDTH-1:0]   quot, remv;
   logic               start;

`ifdef DIV_SIGNED_EN
   logic               is_div;
   logic               neg_q_q, neg_q_d;
   logic               neg_r_q, neg_r_d;
`endif

   div_step #(.W(WIDTH)) u_step (
      .rem_i     (rem_q),
      .q_i       (q_q),
      .divisor_i (divisor_q),
      .rem_o     (step_rem),
      .q_o       (step_q)
   );

   // Next-state, iteration and result-formatting logic.
   always_comb begin
      // NOTE: every _d defaults to its _q first so no branch can infer a latch.
      state_d   = state_q;
      count_d   = count_q;
      rem_d     = rem_q;
      q_d       = q_q;
      divisor_d = divisor_q;
      dout_d    = dout_q;
      done_d    = 1'b0;
      divzero_d = divzero_q;
      quot      = step_q;
      remv      = step_rem[WIDTH-1:0];
`ifdef DIV_SIGNED_EN
      neg_q_d   = neg_q_q;
      neg_r_d   = neg_r_q;
      is_div    = (Signal == DIV);
      start     = (Signal == DIVU) || is_div;
      // Division by zero keeps the all-ones quotient; the remainder
      // correction turns the stored magnitude back into the original dividend.
      if (neg_q_q && (divisor_q != '0)) quot = -step_q;
      if (neg_r_q)                      remv = -step_rem[WIDTH-1:0];
`else
      start     = (Signal == DIVU);
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               count_d   = '0;
               rem_d     = '0;
               q_d       = dataA;
               divisor_d = dataB;
`ifdef DIV_SIGNED_EN
               neg_q_d = is_div & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
               neg_r_d = is_div & dataA[WIDTH-1];
               if (is_div && dataA[WIDTH-1]) q_d       = -dataA;
               if (is_div && dataB[WIDTH-1]) divisor_d = -dataB;
`endif
            end
         end
         RUN: begin
            rem_d   = step_rem;
            q_d     = step_q;
            count_d = count_q + 6'd1;
            if (count_q == LAST) begin
               state_d   = DONE;
               done_d    = 1'b1;
               divzero_d = (divisor_q == '0);
               dout_d    = {remv, quot};
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset clears everything, aborting any run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         rem_q     <= '0;
         q_q       <= '0;
         divisor_q <= '0;
         dout_q    <= '0;
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
`ifdef DIV_SIGNED_EN
         neg_q_q   <= 1'b0;
         neg_r_q   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values together.
         state_q   <= state_d;
         count_q   <= count_d;
         rem_q     <= rem_d;
         q_q       <= q_d;
         divisor_q <= divisor_d;
         dout_q    <= dout_d;
         done_q    <= done_d;
         divzero_q <= divzero_d;
`ifdef DIV_SIGNED_EN
         neg_q_q   <= neg_q_d;
         neg_r_q   <= neg_r_d;
`endif
      end
   end

   assign busy    = (state_q == RUN);
   assign done    = done_q;
   assign divzero = divzero_q;
   assign dataOut = dout_q;

endmodule
